// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions used by every stage: bus widths, reset PC, bus layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

  localparam int          WIDTH_BR_BUS       = 33;
  localparam int          WIDTH_FS_TO_DS_BUS = 64;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h1c000000;

  // Redirect from decode: taken flag above the 32-bit target.
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  // Fetch-to-decode payload: instruction word above its PC.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  // Sequential successor; plain 32-bit add so the top of the space wraps to 0.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fs_inst_buf.sv
// Holding register for the IF instruction while decode stalls, so the SRAM can idle.
// Latency: captures on the clock edge after capture is seen; output valid the next cycle.
// Backpressure: none of its own; clear has priority over capture.
//
// Ports: clk, reset (async, active-high), capture/clear controls,
//        din (SRAM read data), buf_valid / buf_inst (held word).
module fs_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        buf_valid,
  output logic [31:0] buf_inst
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_inst  <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: pre-IF picks nextpc and issues the SRAM read, IF holds pc/inst for decode.
// Latency: one cycle from SRAM request to instruction presented on fs_to_ds_bus.
// Backpressure: ds_allow_in low freezes IF; instruction held stable, branches queued in br_pending.
//
// Ports: clk, reset (async, active-high); ds_allow_in, br_bus {taken, target} from decode;
//        fs_to_ds_valid, fs_to_ds_bus {inst, pc} to decode;
//        inst_sram_en/wen/addr/wdata request, inst_sram_rdata (data of previous-cycle request).
// Build option: FS_INST_BUF_EN -- hold the stalled instruction in a local register and idle
//        the SRAM; when undefined the SRAM re-reads fs_pc every stalled cycle instead.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ds_allow_in,
  input  logic [WIDTH_BR_BUS-1:0]       br_bus,
  output logic                          fs_to_ds_valid,
  output logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus,
  output logic                          inst_sram_en,
  output logic [3:0]                    inst_sram_wen,
  output logic [31:0]                   inst_sram_addr,
  output logic [31:0]                   inst_sram_wdata,
  input  logic [31:0]                   inst_sram_rdata
);

  br_bus_t     br;
  fs_to_ds_t   fs_out;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        br_pending;
  logic [31:0] br_target_q;

  logic        fs_ready_go;
  logic        fs_allow_in;
  logic        cancel;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign br = br_bus;

  assign fs_ready_go = 1'b1;
  assign fs_allow_in = !fs_valid || (fs_ready_go && ds_allow_in);

  // The IF instruction is wrong-path whenever a redirect is live or still queued;
  // it stays masked until IF is refilled from the redirect target.
  assign cancel         = fs_valid && (br.taken || br_pending);
  assign fs_to_ds_valid = fs_valid && !cancel;

  // Live redirect beats a queued one: it is the younger branch.
  always_comb begin
    nextpc = seq_pc(fs_pc);
    if (br.taken) begin
      nextpc = br.target;
    end else if (br_pending) begin
      nextpc = br_target_q;
    end
  end

  // fs_pc resets one word below RESET_PC so the first nextpc is RESET_PC itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allow_in) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

  // A redirect that arrives while IF is frozen is parked until IF can reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_pending  <= 1'b0;
      br_target_q <= 32'h0;
    end else if (fs_allow_in) begin
      br_pending  <= 1'b0;
    end else if (br.taken) begin
      br_pending  <= 1'b1;
      br_target_q <= br.target;
    end
  end

`ifdef FS_INST_BUF_EN
  logic        buf_capture;
  logic        buf_clear;
  logic        buf_valid;
  logic [31:0] buf_inst;

  // First stalled cycle still sees the fresh SRAM data; grab it then.
  assign buf_capture = fs_valid && !ds_allow_in && !buf_valid;
  assign buf_clear   = fs_allow_in || cancel;

  fs_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (buf_capture),
    .clear     (buf_clear),
    .din       (inst_sram_rdata),
    .buf_valid (buf_valid),
    .buf_inst  (buf_inst)
  );

  assign fs_inst        = buf_valid ? buf_inst : inst_sram_rdata;
  assign inst_sram_en   = !reset && fs_allow_in;
  assign inst_sram_addr = nextpc;
`else
  // While stalled keep re-reading fs_pc so rdata keeps carrying the IF instruction.
  assign fs_inst        = inst_sram_rdata;
  assign inst_sram_en   = !reset && (fs_allow_in || fs_valid);
  assign inst_sram_addr = fs_allow_in ? nextpc : fs_pc;
`endif

  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // Instruction field forced to zero in reset; SRAM output is meaningless then.
  always_comb begin
    fs_out.inst = reset ? 32'h0 : fs_inst;
    fs_out.pc   = fs_pc;
  end

  assign fs_to_ds_bus = fs_out;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allow_in = 1'b0;
  logic [32:0] br_bus = 33'h0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int delivered = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allow_in     (ds_allow_in),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  // Program image: every address holds a distinct pseudo-random word.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9e3779b1) ^ 32'h5bd1e995;
  endfunction

  // Synchronous SRAM; output is junk after a cycle with no request.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural next PC. A taken branch replaces whatever was expected
  // with its target; each delivery expects the following word next.
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        hold_vld = 1'b0;
  logic [63:0] hold_bus = 64'h0;

  task automatic issue_branch(input logic [31:0] tgt);
    br_bus = {1'b1, tgt};
    exp_q.delete();
    exp_q.push_back(tgt);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_q.push_back(RPC);
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && fs_to_ds_valid)
        check("hold_stable", fs_to_ds_bus, hold_bus);
      if (fs_to_ds_valid && ds_allow_in) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL deliver: got pc %h, expected nothing", fs_to_ds_bus[31:0]);
        end else begin
          exp_pc = exp_q.pop_front();
          check("deliver", fs_to_ds_bus, {inst_of(exp_pc), exp_pc});
          exp_q.push_back(exp_pc + 32'd4);
          delivered++;
        end
      end
      hold_vld = fs_to_ds_valid && !ds_allow_in;
      hold_bus = fs_to_ds_bus;
    end
  end

  task automatic cyc(input logic allow, input logic take, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    ds_allow_in = allow;
    br_bus = 33'h0;
    if (take) issue_branch(tgt);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(fs_to_ds_valid), 64'd0);
    check({tag, "_en"},    64'(inst_sram_en),   64'd0);
    check({tag, "_wen"},   64'(inst_sram_wen),  64'd0);
    check({tag, "_wdata"}, 64'(inst_sram_wdata), 64'd0);
    check({tag, "_bus"},   fs_to_ds_bus, {32'h0, RPC - 32'd4});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ds_allow_in = 1'b1;
    br_bus = 33'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // Reset release: first request is RESET_PC
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("k0_addr", 64'(inst_sram_addr), 64'(RPC));
    check("k0_en", 64'(inst_sram_en), 64'd1);
    check("k0_valid", 64'(fs_to_ds_valid), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      check("seq_addr", 64'(inst_sram_addr), 64'(RPC + 32'(4 * k)));
      check("seq_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC + 32'(4 * (k - 1))));
    end

    // Three-cycle stall at 0x1c000010
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      check("stall_valid", 64'(fs_to_ds_valid), 64'd1);
      check("stall_bus", fs_to_ds_bus, {inst_of(RPC + 32'h10), RPC + 32'h10});
    end
    cyc(1'b1, 1'b0, 32'h0);
    check("release_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC + 32'h10));
    cyc(1'b1, 1'b0, 32'h0);
    check("after_stall_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC + 32'h14));
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);

    // Branch while 0x1c000020 sits in IF
    cyc(1'b1, 1'b1, RPC + 32'h100);
    check("br_cancel_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC + 32'h20));
    check("br_cancel_valid", 64'(fs_to_ds_valid), 64'd0);
    check("br_addr", 64'(inst_sram_addr), 64'(RPC + 32'h100));
    cyc(1'b1, 1'b0, 32'h0);
    check("br_target_valid", 64'(fs_to_ds_valid), 64'd1);
    check("br_target_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC + 32'h100));

    // Branch during a stall is parked and applied on release
    cyc(1'b0, 1'b1, RPC + 32'h200);
    check("pend_cancel", 64'(fs_to_ds_valid), 64'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check("pend_masked", 64'(fs_to_ds_valid), 64'd0);
    cyc(1'b1, 1'b0, 32'h0);
    check("pend_masked2", 64'(fs_to_ds_valid), 64'd0);
    check("pend_addr", 64'(inst_sram_addr), 64'(RPC + 32'h200));
    cyc(1'b1, 1'b0, 32'h0);
    check("pend_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC + 32'h200));

    // Reset mid-stall with a parked branch
    cyc(1'b0, 1'b1, RPC + 32'h300);
    cyc(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ds_allow_in = 1'b1;
    @(negedge clk);
    check("restart_addr", 64'(inst_sram_addr), 64'(RPC));
    cyc(1'b1, 1'b0, 32'h0);
    check("restart_pc", 64'(fs_to_ds_bus[31:0]), 64'(RPC));

    // Address wrap at the top of the space
    cyc(1'b1, 1'b1, 32'hfffffff8);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    check("wrap_pc", 64'(fs_to_ds_bus[31:0]), 64'd0);
    check("wrap_valid", 64'(fs_to_ds_valid), 64'd1);

    // Random stalls, branches and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      br_bus = 33'h0;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      ds_allow_in = ($urandom_range(0, 1) == 1);
      if (!reset && $urandom_range(0, 7) == 0)
        issue_branch(RPC + ($urandom_range(0, 255) << 2));
    end
    @(posedge clk);
    #1;
    br_bus = 33'h0;
    ds_allow_in = 1'b1;
    @(negedge clk);
    check("delivered_enough", 64'(delivered > 1000), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, first instruction address fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ds_allow_in  input  1  decode can accept an instruction this cycle.
REQ-005 SHALL have port br_bus  input  33  {br_taken[32], br_target[31:0]} from decode.
REQ-006 SHALL have port fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction.
REQ-007 SHALL have port fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.
REQ-008 SHALL have ports inst_sram_en  output  1, inst_sram_wen  output  4, inst_sram_addr  output  32, inst_sram_wdata  output  32  (synchronous SRAM request; rdata valid one cycle after en).
REQ-009 SHALL have port inst_sram_rdata  input  32  read data of previous-cycle request.

Function
REQ-010 SHALL split into pre-IF (nextpc, SRAM request) and IF (fs_valid, fs_pc, instruction) with fs_ready_go = 1.
REQ-011 SHALL compute fs_allow_in = !fs_valid || (fs_ready_go && ds_allow_in); fs_to_ds_valid = fs_valid && !cancel.
REQ-012 SHALL select nextpc: taken redirect (live br_taken or br_pending) -> target; else fs_pc + 4, 32-bit wrap (32'hfffffffc + 4 = 0).
REQ-013 SHALL drive inst_sram_en = fs_allow_in (after reset release), inst_sram_addr = nextpc, inst_sram_wen = 4'h0, inst_sram_wdata = 32'h0.
REQ-014 SHALL on fs_allow_in load fs_pc <= nextpc, fs_valid <= 1, one-cycle fetch latency.
REQ-015 SHALL, when br_taken = 1 while fs_valid = 1, treat the IF instruction as wrong-path: cancel = 1, fs_to_ds_valid = 0 that cycle, not delivered later.
REQ-016 SHALL, when br_taken = 1 and fs_allow_in = 0, set br_pending and latch br_target in br_target_q; apply at next fs_allow_in, then clear.
REQ-017 SHALL let a live br_taken coinciding with br_pending take priority (newer target wins).
REQ-018 SHALL present fs_inst = inst_sram_rdata, or the held instruction per REQ-024/025, stable while fs_to_ds_valid && !ds_allow_in.
REQ-019 SHALL deliver each fetched PC to decode exactly once, in program order, none lost or duplicated across arbitrary ds_allow_in stall patterns.

Reset
REQ-020 SHALL asynchronously clear fs_valid, br_pending, buffer-valid; fs_pc <= RESET_PC - 4, br_target_q <= 0.
REQ-021 SHALL hold outputs in reset: fs_to_ds_valid = 0, inst_sram_en = 0, inst_sram_wen = 0, inst_sram_wdata = 0, fs_to_ds_bus = {32'h0, RESET_PC-4}.
REQ-022 SHALL issue first request addr = RESET_PC in the first cycle after reset deasserts.
REQ-023 SHALL abandon any in-flight fetch, pending branch or buffered instruction if reset asserts mid-operation.

Configuration
REQ-024 With FS_INST_BUF_EN defined: on fs_valid && !ds_allow_in with buffer empty, SHALL capture inst_sram_rdata into inst_buf, set buf_valid, select inst_buf; clear on fs_allow_in or cancel; inst_sram_en = 0 while stalled.
REQ-025 Without FS_INST_BUF_EN: while fs_valid && !fs_allow_in, SHALL drive inst_sram_en = 1, inst_sram_addr = fs_pc (re-read), fs_inst = inst_sram_rdata; cycle-level fs_to_ds_* identical to buffered build.

Structure
REQ-026 SHALL take WIDTH_BR_BUS (33), WIDTH_FS_TO_DS_BUS (64), default RESET_PC from the shared pipeline package/header used by all stages.
REQ-027 SHALL be one module; the optional buffer may be sub-module fs_inst_buf (32-bit holding register + valid).

Verification
REQ-028 Reset release, ds_allow_in = 1 -> addr 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; fs_pc one cycle behind each.
REQ-029 ds_allow_in low 3 cycles with fs_pc = 0x1c000010 -> fs_to_ds_bus = {inst@0x1c000010, 0x1c000010} stable all 3 cycles, next PC 0x1c000014 after release; both macro builds.
REQ-030 br_taken, br_target = 0x1c000100, fs holds 0x1c000020 -> 0x1c000020 never valid to decode; next delivered PC 0x1c000100.
REQ-031 br_taken, target 0x1c000200 during stall -> after release next request 0x1c000200, no fall-through PC delivered.
REQ-032 Reset asserted mid-stall with pending branch -> outputs per REQ-021 immediately; after release fetch restarts at 0x1c000000.
REQ-033 Random ds_allow_in 50%, random branches, vs reference PC model -> delivered PC/inst sequence identical, no duplicates.
